dma_writer: RTL



---
 rtl/dma_writer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dma_writer.sv
// AXI3 write DMA: streams words from an upstream FIFO into memory as INCR bursts
// that never cross a 4 KB page, tracking outstanding bursts and reporting bus errors.
module dma_writer #(
  parameter int DataBits        = 64,
  parameter int AddrBits        = 32,
  parameter int LengthBits      = 16,
  parameter int BurstBits       = 5,
  parameter int FifoUsedBits    = 10,
  parameter int OutstandingBits = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AddrBits-1:0]     cfg_dest,
  input  logic [LengthBits-1:0]   cfg_len,
  input  logic [BurstBits-1:0]    cfg_burst,
  input  logic                    cfg_valid,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic [LengthBits-1:0]   cfg_remain,
  output logic [1:0]              cfg_err,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [DataBits-1:0]     din_data,
  input  logic [FifoUsedBits-1:0] din_fifo_used,
  output logic                    mst_awvalid,
  input  logic                    mst_awready,
  output logic [AddrBits-1:0]     mst_awaddr,
  output logic [3:0]              mst_awlen,
  output logic [3:0]              mst_awid,
  output logic [2:0]              mst_awsize,
  output logic [1:0]              mst_awburst,
  output logic [1:0]              mst_awlock,
  output logic                    mst_wvalid,
  input  logic                    mst_wready,
  output logic [DataBits-1:0]     mst_wdata,
  output logic [DataBits/8-1:0]   mst_wstrb,
  output logic                    mst_wlast,
  output logic [3:0]              mst_wid,
  input  logic                    mst_bvalid,
  output logic                    mst_bready,
  input  logic [3:0]              mst_bid,
  input  logic [1:0]              mst_bresp
);
  localparam int BytesPerWord = DataBits / 8;
  localparam int WordShift    = $clog2(BytesPerWord);
  localparam int QDepth       = 1 << OutstandingBits;
  localparam int CommitBits   = FifoUsedBits + 1;
  localparam int PageBits     = 11;

  typedef enum logic [2:0] {IDLE, PREP1, PREP2, ISSUE, WAIT_RESP, DONE} state_t;
  state_t state, state_nx;

  logic [LengthBits-1:0]   remain;
  logic [AddrBits-1:0]     next_addr;
  logic [BurstBits-1:0]    burst_max, burst_cand, next_burst;
  logic [PageBits-1:0]     until_4k;
  logic [12:0]             page_room;
  logic [CommitBits-1:0]   committed;
  logic [LengthBits-1:0]   bursts_out;
  logic [BurstBits-1:0]    q_mem [QDepth];
  logic [OutstandingBits-1:0] wr_ptr, rd_ptr;
  logic [OutstandingBits:0]   q_count;
  logic [BurstBits-1:0]    beat, head;
  logic                    q_full, q_active, fifo_ok, issue, w_hs, pop, accept;
  logic                    unused_bits;

  function automatic logic [BurstBits-1:0] clip_burst(input logic [LengthBits-1:0] rem,
                                                      input logic [BurstBits-1:0] lim);
    return (rem < LengthBits'(lim)) ? BurstBits'(rem) : lim;
  endfunction

  function automatic logic [BurstBits-1:0] clip_page(input logic [BurstBits-1:0] cand,
                                                     input logic [PageBits-1:0] room);
    return (PageBits'(cand) < room) ? cand : BurstBits'(room);
  endfunction

  assign page_room = 13'h1000 - {1'b0, next_addr[11:0]};
  assign q_full    = (q_count == (OutstandingBits+1)'(QDepth));
  assign q_active  = (q_count != '0);
  assign fifo_ok   = ((FifoUsedBits+2)'(din_fifo_used)) >=
                     ((FifoUsedBits+2)'(committed) + (FifoUsedBits+2)'(next_burst));
  assign issue     = (state == ISSUE) && fifo_ok && !q_full && (!mst_awvalid || mst_awready);
  assign accept    = (state == IDLE) && cfg_valid;

  // W path is a pure pass-through gated by a pending burst at the queue head
  assign head       = q_mem[rd_ptr];
  assign mst_wvalid = din_valid & q_active;
  assign din_ready  = mst_wready & q_active;
  assign mst_wdata  = din_data;
  assign mst_wlast  = q_active && (beat == head - BurstBits'(1));
  assign w_hs       = mst_wvalid & mst_wready;
  assign pop        = w_hs & mst_wlast;

  assign mst_awid    = '0;
  assign mst_awsize  = 3'(WordShift);
  assign mst_awburst = 2'b01;
  assign mst_awlock  = '0;
  assign mst_wstrb   = '1;
  assign mst_wid     = '0;
  assign mst_bready  = 1'b1;
  assign unused_bits = ^mst_bid;

  assign cfg_busy   = (state != IDLE);
  assign cfg_done   = (state == DONE);
  assign cfg_remain = remain;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (cfg_valid) state_nx = (cfg_len != '0) ? PREP1 : DONE;
      PREP1:     state_nx = (remain != '0) ? PREP2 : WAIT_RESP;
      PREP2:     state_nx = ISSUE;
      ISSUE:     if (issue) state_nx = PREP1;
      WAIT_RESP: if (!q_active && bursts_out == '0) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remain      <= '0;
      committed   <= '0;
      bursts_out  <= '0;
      cfg_err     <= '0;
      mst_awvalid <= 1'b0;
      q_count     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      beat        <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        remain  <= cfg_len;
        cfg_err <= '0;
      end else if (mst_bvalid && mst_bresp != 2'b00 && cfg_err == 2'b00) begin
        cfg_err <= mst_bresp;
      end
      if (issue) remain <= remain - LengthBits'(next_burst);
      if (issue)            mst_awvalid <= 1'b1;
      else if (mst_awready) mst_awvalid <= 1'b0;
      committed  <= committed + (issue ? CommitBits'(next_burst) : '0)
                              - (w_hs ? CommitBits'(1) : '0);
      bursts_out <= bursts_out + (issue ? LengthBits'(1) : '0)
                               - (mst_bvalid ? LengthBits'(1) : '0);
      if (issue) wr_ptr <= wr_ptr + OutstandingBits'(1);
      if (pop)   rd_ptr <= rd_ptr + OutstandingBits'(1);
      case ({issue, pop})
        2'b10:   q_count <= q_count + (OutstandingBits+1)'(1);
        2'b01:   q_count <= q_count - (OutstandingBits+1)'(1);
        default: q_count <= q_count;
      endcase
      if (w_hs) beat <= mst_wlast ? '0 : beat + BurstBits'(1);
    end
  end

  // Burst sizing datapath: Prep1 computes both limits, Prep2 picks the tighter
  always_ff @(posedge clk) begin
    if (accept) begin
      next_addr <= cfg_dest;
      burst_max <= cfg_burst;
    end
    if (state == PREP1) begin
      burst_cand <= clip_burst(remain, burst_max);
      until_4k   <= PageBits'(page_room >> WordShift);
    end
    if (state == PREP2) next_burst <= clip_page(burst_cand, until_4k);
    if (issue) begin
      mst_awaddr     <= next_addr;
      mst_awlen      <= 4'(next_burst - BurstBits'(1));
      next_addr      <= next_addr + (AddrBits'(next_burst) << WordShift);
      q_mem[wr_ptr]  <= next_burst;
    end
  end
endmodule
